axi_line_master: RTL and testbench

- Upstream AXI4 master for the simulation SRAM.
- Turns one cache-line request from the cache/LSU side into a single AXI4 INCR burst: a read burst for a refill, or an AW+W+B sequence for a writeback.
- Holds one request at a time and returns the full line (read) or a completion (write) on a one-cycle response pulse.

---
 rtl/axi_line_master_if.sv | 67 ++++++
 rtl/axi_line_master.sv | 143 ++++++++++++++
 tb/tb_axi_line_master.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_line_master_if.sv
// AXI4 bus bundle between axi_line_master and the SRAM slave.
// Carries the AR/R/AW/W/B channels: 32-bit address, 64-bit data, 4-bit IDs.
// The master modport drives addresses, write data and the ready signals for
// R and B. The slave modport is its mirror image.
interface axi_line_master_if;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;

  logic        rvalid, rready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;

  logic        wvalid, wready;
  logic [3:0]  wid;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;

  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot,
    input  awready,
    output wvalid, wid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot,
    output awready,
    input  wvalid, wid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready
  );
endinterface

// File: rtl/axi_line_master.sv
// Cache-line AXI4 master.
// Each accepted request becomes one INCR burst of LINE_BEATS 64-bit beats:
// a refill does AR then R, and a writeback does AW, then W, then B.
// Only one request is in flight at a time. Completion is signalled by a
// one-cycle resp_valid pulse.
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   req_valid/req_ready  request handshake; ready only while idle
//   req_wen              1 = writeback, 0 = refill
//   req_addr             line address; the offset bits are dropped
//   req_wdata            writeback line, beat 0 in the low 64 bits
//   resp_valid           completion pulse
//   resp_rdata           last refilled line; held until the next read finishes
//   resp_err             error flag, qualified by resp_valid
//   axi                  AXI4 master modport
module axi_line_master #(
  parameter int         LINE_BEATS = 4,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wen,
  input  logic [31:0]               req_addr,
  input  logic [64*LINE_BEATS-1:0]  req_wdata,
  output logic                      resp_valid,
  output logic [64*LINE_BEATS-1:0]  resp_rdata,
  output logic                      resp_err,
  axi_line_master_if.master         axi
);
  localparam int OFF = $clog2(8*LINE_BEATS);
  localparam int IW  = $clog2(LINE_BEATS);
  // One extra bit so the count can reach LINE_BEATS. The MSB then marks a
  // full line.
  localparam int CW  = IW + 1;
  localparam logic [CW-1:0] LAST  = CW'(LINE_BEATS-1);
  localparam logic [31:0]   AMASK = ~((32'd1 << OFF) - 32'd1);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RESP} state_e;

  state_e                       state_q;
  logic [CW-1:0]                cnt_q;
  logic                         err_q;
  logic [31:0]                  addr_q;
  logic [LINE_BEATS-1:0][63:0]  wbuf_q, line_q, line_d, resp_rdata_q;
  logic                         r_hs, rd_err;

  assign r_hs = (state_q == S_R) && axi.rvalid;

  // A beat only lands in the line while a slot is still free. Extra beats
  // from a slave that overruns are dropped.
  always_comb begin
    line_d = line_q;
    if (r_hs && !cnt_q[CW-1]) line_d[cnt_q[IW-1:0]] = axi.rdata;
  end

  // A beat is in error if it carries a bad response, or if rlast does not
  // line up with the final slot.
  assign rd_err = (axi.rresp != 2'b00)
                | (axi.rlast  && (cnt_q != LAST))
                | (!axi.rlast && (cnt_q >= LAST));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wbuf_q       <= '0;
      line_q       <= '0;
      resp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (req_valid) begin
          addr_q  <= req_addr & AMASK;
          wbuf_q  <= req_wdata;
          err_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= req_wen ? S_AW : S_AR;
        end
        S_AR: if (axi.arready) state_q <= S_R;
        S_R: if (axi.rvalid) begin
          line_q <= line_d;
          if (!cnt_q[CW-1]) cnt_q <= cnt_q + CW'(1);
          err_q  <= err_q | rd_err;
          if (axi.rlast) begin
            resp_rdata_q <= line_d;
            state_q      <= S_RESP;
          end
        end
        S_AW: if (axi.awready) state_q <= S_W;
        S_W: if (axi.wready) begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) state_q <= S_B;
        end
        S_B: if (axi.bvalid) begin
          err_q   <= err_q | (axi.bresp != 2'b00);
          state_q <= S_RESP;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = err_q;
  assign resp_rdata = resp_rdata_q;

  assign axi.arvalid = (state_q == S_AR);
  assign axi.araddr  = addr_q;
  assign axi.arid    = AXI_ID;
  assign axi.arlen   = 8'(LINE_BEATS-1);
  assign axi.arsize  = 3'b011;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.rready  = (state_q == S_R);

  assign axi.awvalid = (state_q == S_AW);
  assign axi.awaddr  = addr_q;
  assign axi.awid    = AXI_ID;
  assign axi.awlen   = 8'(LINE_BEATS-1);
  assign axi.awsize  = 3'b011;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;

  assign axi.wvalid  = (state_q == S_W);
  assign axi.wid     = AXI_ID;
  assign axi.wdata   = wbuf_q[cnt_q[IW-1:0]];
  assign axi.wstrb   = 8'hFF;
  assign axi.wlast   = (cnt_q == LAST);
  assign axi.bready  = (state_q == S_B);

  // Response IDs are ignored; a single request is outstanding.
  logic unused_ok;
  assign unused_ok = ^{axi.rid, axi.bid};
endmodule

// File: tb/tb_axi_line_master.sv
module tb_axi_line_master;
  localparam int N  = 4;
  localparam int LW = 64*N;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          req_valid, req_ready, req_wen;
  logic [31:0]   req_addr;
  logic [LW-1:0] req_wdata;
  logic          resp_valid, resp_err;
  logic [LW-1:0] resp_rdata;

  always #5 aclk = ~aclk;

  axi_line_master_if axi();

  axi_line_master #(.LINE_BEATS(N), .AXI_ID(4'd0)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .axi(axi)
  );

  typedef struct {
    logic          wen;
    logic [LW-1:0] rdata;
    logic          err;
    bit            chk_data;
    bit            chk_lat;
    int            acc_cyc;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0, errors = 0;
  int            cyc = 0;
  int            last_resp_cyc = 0;
  logic [LW-1:0] last_rd = '0;
  bit            known = 1'b1;
  bit            prev_resp = 1'b0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  // Response monitor: pops the scoreboard on every completion pulse.
  always @(negedge aclk) begin
    exp_t e;
    if (!aresetn) begin
      sb.delete();
      last_rd   = '0;
      known     = 1'b1;
      prev_resp = 1'b0;
    end else begin
      if (axi.arvalid || axi.awvalid)
        check("ar_aw_excl", axi.arvalid & axi.awvalid, 0);
      if (resp_valid) begin
        check("resp_pulse", prev_resp, 0);
        if (sb.size() == 0) check("spurious_resp", 1, 0);
        else begin
          e = sb.pop_front();
          check("resp_err", resp_err, e.err);
          if (!e.wen) begin
            if (e.chk_data) begin
              check("resp_rdata", resp_rdata, e.rdata);
              last_rd = e.rdata;
              known   = 1'b1;
            end else known = 1'b0;
            if (e.chk_lat) check("rd_latency", cyc - e.acc_cyc + 1, 3 + N);
          end else if (known) check("rdata_hold", resp_rdata, last_rd);
        end
        last_resp_cyc = cyc;
      end
      prev_resp = resp_valid;
    end
  end

  task automatic req_one(input logic wen, input logic [31:0] addr, input logic [LW-1:0] wdata,
                         input logic [LW-1:0] exp_rd, input logic exp_err,
                         input bit chk_data, input bit chk_lat, input bit hold, input bit b2b);
    int t = 0;
    exp_t e;
    @(negedge aclk);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    while (!req_ready && t < 300) begin @(negedge aclk); t++; end
    check("req_accept", req_ready, 1);
    if (b2b) check("b2b_accept", cyc, last_resp_cyc + 1);
    e.wen = wen; e.rdata = exp_rd; e.err = exp_err;
    e.chk_data = chk_data; e.chk_lat = chk_lat; e.acc_cyc = cyc;
    sb.push_back(e);
    @(negedge aclk);
    if (!hold) req_valid = 1'b0;
  endtask

  // Zero-wait read slave. It sends nbeats beats and raises rlast on beat last_at.
  task automatic r_slave(input logic [31:0] exp_addr, input logic [LW-1:0] line, input int nbeats,
                         input int last_at, input int bad_beat, input logic [1:0] bad_resp);
    int t = 0;
    @(negedge aclk);
    while (!axi.arvalid && t < 300) begin @(negedge aclk); t++; end
    check("ar_seen", axi.arvalid, 1);
    check("araddr", axi.araddr, exp_addr);
    check("ar_fmt", {axi.arid, axi.arlen, axi.arsize, axi.arburst}, {4'd0, 8'd3, 3'd3, 2'd1});
    check("ar_zero", {axi.arlock, axi.arcache, axi.arprot}, 0);
    for (int b = 0; b < nbeats; b++) begin
      @(negedge aclk);
      if (b == N) check("stay_in_r", {axi.rready, resp_valid}, 2'b10);
      axi.rvalid = 1'b1;
      axi.rdata  = (b < N) ? line[64*b +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
      axi.rlast  = (b == last_at);
      axi.rresp  = (b == bad_beat) ? bad_resp : 2'b00;
    end
    @(negedge aclk);
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
  endtask

  // Write slave. It delays awready by aw_dly cycles and can toggle wready.
  // abort_at >= 0 pulls reset once that many beats have been accepted.
  task automatic w_slave(input logic [31:0] exp_addr, input logic [LW-1:0] line, input int aw_dly,
                         input bit toggle, input logic [1:0] bresp, input int abort_at);
    int t = 0, beat = 0, k = 0;
    @(negedge aclk);
    while (!axi.awvalid && t < 300) begin @(negedge aclk); t++; end
    check("aw_seen", axi.awvalid, 1);
    check("awaddr", axi.awaddr, exp_addr);
    check("aw_fmt", {axi.awid, axi.awlen, axi.awsize, axi.awburst}, {4'd0, 8'd3, 3'd3, 2'd1});
    check("aw_zero", {axi.awlock, axi.awcache, axi.awprot}, 0);
    for (int i = 0; i < aw_dly; i++) begin
      @(negedge aclk);
      check("aw_hold", {axi.awvalid, axi.awaddr}, {1'b1, exp_addr});
    end
    axi.awready = 1'b1;
    @(negedge aclk);
    axi.awready = 1'b0;
    while (beat < N && k < 100) begin
      if (beat == abort_at) begin
        axi.wready = 1'b0;
        aresetn    = 1'b0;
        @(negedge aclk);
        check("rst_mid_w", {axi.wvalid, req_ready, resp_valid}, 3'b010);
        @(negedge aclk);
        aresetn = 1'b1;
        return;
      end
      axi.wready = toggle ? ~k[0] : 1'b1;
      check("w_beat", {axi.wvalid, axi.wlast, axi.wstrb, axi.wid, axi.wdata},
            {1'b1, beat == N-1, 8'hFF, 4'd0, line[64*beat +: 64]});
      if (axi.wready) beat++;
      k++;
      @(negedge aclk);
    end
    axi.wready = 1'b0;
    check("w_done", beat, N);
    check("bready", axi.bready, 1);
    axi.bvalid = 1'b1; axi.bresp = bresp;
    @(negedge aclk);
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin @(negedge aclk); t++; end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] l1, l2, l3, w1, w2;
    l1 = {64'h44, 64'h33, 64'h22, 64'h11};
    for (int i = 0; i < N; i++) begin
      l2[64*i +: 64] = 64'hA5A5_0000_0000_0000 + 64'(i);
      l3[64*i +: 64] = 64'h5A5A_0000_1111_0000 + 64'(i);
      w1[64*i +: 64] = 64'hDDDD_0000_0000_00D0 + 64'(i);
      w2[64*i +: 64] = 64'hEEEE_1234_0000_0000 + 64'(i);
    end
    aresetn = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    axi.arready = 1'b1; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.rvalid = 1'b0; axi.rid = 4'd0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0;
    axi.bvalid = 1'b0; axi.bid = 4'd0; axi.bresp = 2'b00;
    repeat (3) @(negedge aclk);
    check("rst_req_ready", req_ready, 1);
    check("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready,
                         resp_valid, resp_err}, 0);
    check("rst_rdata", resp_rdata, 0);
    aresetn = 1'b1;

    // refill, zero-wait
    fork
      req_one(1'b0, 32'h8000_0018, '0, l1, 1'b0, 1, 1, 0, 0);
      r_slave(32'h8000_0000, l1, 4, 3, -1, 2'b00);
    join
    wait_drain();

    // writeback, delayed awready, wready toggling
    fork
      req_one(1'b1, 32'h8000_103C, w1, '0, 1'b0, 0, 0, 0, 0);
      w_slave(32'h8000_1020, w1, 3, 1, 2'b00, -1);
    join
    wait_drain();

    // rresp error on beat 2; all beats still stored
    fork
      req_one(1'b0, 32'h0000_0040, '0, l2, 1'b1, 1, 1, 0, 0);
      r_slave(32'h0000_0040, l2, 4, 3, 2, 2'b10);
    join
    wait_drain();

    // bresp error
    fork
      req_one(1'b1, 32'h0000_2008, w2, '0, 1'b1, 0, 0, 0, 0);
      w_slave(32'h0000_2000, w2, 0, 0, 2'b11, -1);
    join
    wait_drain();

    // rlast early on beat 1
    fork
      req_one(1'b0, 32'h0000_0100, '0, '0, 1'b1, 0, 0, 0, 0);
      r_slave(32'h0000_0100, l3, 2, 1, -1, 2'b00);
    join
    wait_drain();

    // rlast withheld on beat 3, arrives on an extra beat
    fork
      req_one(1'b0, 32'h0000_0200, '0, l3, 1'b1, 1, 0, 0, 0);
      r_slave(32'h0000_0200, l3, 5, 4, -1, 2'b00);
    join
    wait_drain();

    // reset after two write beats, then a clean read
    fork
      req_one(1'b1, 32'h0000_0300, w1, '0, 1'b0, 0, 0, 0, 0);
      w_slave(32'h0000_0300, w1, 0, 0, 2'b00, 2);
    join
    repeat (5) @(negedge aclk);
    wait_drain();
    fork
      req_one(1'b0, 32'h0000_0400, '0, l1, 1'b0, 1, 1, 0, 0);
      r_slave(32'h0000_0400, l1, 4, 3, -1, 2'b00);
    join
    wait_drain();

    // back-to-back read then write with req_valid held
    fork
      begin
        req_one(1'b0, 32'h0000_0500, '0, l2, 1'b0, 1, 1, 1, 0);
        req_one(1'b1, 32'h0000_0600, w2, '0, 1'b0, 0, 0, 0, 1);
      end
      begin
        r_slave(32'h0000_0500, l2, 4, 3, -1, 2'b00);
        w_slave(32'h0000_0600, w2, 0, 0, 2'b00, -1);
      end
    join
    wait_drain();
    repeat (3) @(negedge aclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
